// File: rtl/mac_tx_gmii_pkg.sv
// Shared constants, state encoding and CRC-32 helpers for the GMII transmit MAC.
package mac_tx_gmii_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int unsigned PREAMBLE_LEN  = 7;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = '1;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PTR_RD,
    S_PTR_LAT,
    S_PRE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG,
    S_DROP
  } state_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // LSB-first update of the reflected CRC register by one byte.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ reflect32(CRC32_POLY);
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_tx_gmii_crc32_d8.sv
// Byte-wide reflected CRC-32 register with synchronous re-initialisation.
module crc32_d8
  import mac_tx_gmii_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     crc <= CRC32_INIT;
    else if (init) crc <= CRC32_INIT;
    else if (en)   crc <= crc32_byte(crc, data);
  end

endmodule

// File: rtl/mac_tx_gmii.sv
// GMII transmit MAC: pops a length descriptor, frames the bytes with
// preamble/SFD, zero padding and FCS, then enforces the inter-frame gap.
module mac_tx_gmii
  import mac_tx_gmii_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned MIN_LEN    = 60,
  parameter int unsigned MAX_LEN    = 1514
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tx_enable,
  input  logic        ptr_fifo_empty,
  output logic        ptr_fifo_rd,
  input  logic [15:0] ptr_fifo_dout,
  output logic        data_fifo_rd,
  input  logic [7:0]  data_fifo_dout,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [31:0] tx_frame_cnt,
  output logic [15:0] tx_drop_cnt
);

  localparam logic [11:0] MIN_L = 12'(MIN_LEN);
  localparam logic [11:0] MAX_L = 12'(MAX_LEN);
  localparam logic [11:0] IFG_L = 12'(IFG_CYCLES);
  localparam logic [11:0] PRE_L = 12'(PREAMBLE_LEN);

  state_t      state, state_n;
  logic [11:0] cnt, cnt_n;
  logic [11:0] len, len_n;
  logic [7:0]  txd_n;
  logic        txen_n;
  logic        crc_en, crc_init;
  logic [7:0]  crc_din;
  logic [31:0] crc, crc_inv;
  logic        frame_inc, drop_inc;
  logic        unused_desc_bits;

  assign unused_desc_bits = ^ptr_fifo_dout[15:12];
  assign crc_inv          = ~crc;
  assign gmii_tx_er       = 1'b0;

  crc32_d8 u_crc (
    .clk  (clk),
    .rstn (rstn),
    .init (crc_init),
    .en   (crc_en),
    .data (crc_din),
    .crc  (crc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  end

  // Byte reads lead the wire by one cycle: the SFD cycle fetches the first
  // byte and the last DATA cycle fetches nothing.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    len_n        = len;
    txd_n        = '0;
    txen_n       = 1'b0;
    crc_en       = 1'b0;
    crc_init     = 1'b0;
    crc_din      = data_fifo_dout;
    frame_inc    = 1'b0;
    drop_inc     = 1'b0;
    data_fifo_rd = 1'b0;
    ptr_fifo_rd  = 1'b0;
    case (state)
      S_IDLE: if (tx_enable && !ptr_fifo_empty) state_n = S_PTR_RD;
      S_PTR_RD: begin
        ptr_fifo_rd = 1'b1;
        state_n     = S_PTR_LAT;
      end
      S_PTR_LAT: begin
        len_n = ptr_fifo_dout[11:0];
        cnt_n = '0;
        if (ptr_fifo_dout[11:0] == '0) begin
          drop_inc = 1'b1;
          state_n  = S_IDLE;
        end else if (ptr_fifo_dout[11:0] > MAX_L) begin
          state_n = S_DROP;
        end else begin
          state_n = S_PRE;
        end
      end
      S_PRE: begin
        txd_n  = PREAMBLE_BYTE;
        txen_n = 1'b1;
        cnt_n  = cnt + 12'd1;
        if (cnt == PRE_L - 12'd1) begin
          cnt_n   = '0;
          state_n = S_SFD;
        end
      end
      S_SFD: begin
        txd_n        = SFD_BYTE;
        txen_n       = 1'b1;
        data_fifo_rd = 1'b1;
        cnt_n        = '0;
        state_n      = S_DATA;
      end
      S_DATA: begin
        txd_n        = data_fifo_dout;
        txen_n       = 1'b1;
        crc_en       = 1'b1;
        data_fifo_rd = (cnt + 12'd1 < len);
        cnt_n        = cnt + 12'd1;
        if (cnt == len - 12'd1) begin
          if (len < MIN_L) begin
            state_n = S_PAD;
          end else begin
            cnt_n   = '0;
            state_n = S_FCS;
          end
        end
      end
      S_PAD: begin
        txen_n  = 1'b1;
        crc_en  = 1'b1;
        crc_din = '0;
        cnt_n   = cnt + 12'd1;
        if (cnt == MIN_L - 12'd1) begin
          cnt_n   = '0;
          state_n = S_FCS;
        end
      end
      S_FCS: begin
        txd_n  = crc_inv[{cnt[1:0], 3'b000} +: 8];
        txen_n = 1'b1;
        cnt_n  = cnt + 12'd1;
        if (cnt[1:0] == 2'd3) begin
          frame_inc = 1'b1;
          cnt_n     = '0;
          state_n   = S_IFG;
        end
      end
      S_IFG: begin
        crc_init = 1'b1;
        cnt_n    = cnt + 12'd1;
        if (cnt == IFG_L - 12'd1) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end
      end
      S_DROP: begin
        data_fifo_rd = 1'b1;
        cnt_n        = cnt + 12'd1;
        if (cnt == len - 12'd1) begin
          drop_inc = 1'b1;
          cnt_n    = '0;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt          <= '0;
      len          <= '0;
      gmii_txd     <= '0;
      gmii_tx_en   <= 1'b0;
      tx_frame_cnt <= '0;
      tx_drop_cnt  <= '0;
    end else begin
      cnt        <= cnt_n;
      len        <= len_n;
      gmii_txd   <= txd_n;
      gmii_tx_en <= txen_n;
      if (frame_inc)                      tx_frame_cnt <= tx_frame_cnt + 32'd1;
      if (drop_inc && tx_drop_cnt != '1)  tx_drop_cnt  <= tx_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mac_tx_gmii.sv
// Scoreboard bench for mac_tx_gmii: stimulus pushes expected wire bytes,
// negedge monitors pop and compare whenever tx_en is high.
module tb_mac_tx_gmii;
  import mac_tx_gmii_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic tx_enable = 1'b0;

  logic        ptr_fifo_empty, ptr_fifo_rd, data_fifo_rd, gmii_tx_en, gmii_tx_er;
  logic [15:0] ptr_fifo_dout = '0;
  logic [7:0]  data_fifo_dout = '0;
  logic [7:0]  gmii_txd;
  logic [31:0] tx_frame_cnt;
  logic [15:0] tx_drop_cnt;

  logic        ptr_fifo_empty0, ptr_fifo_rd0, data_fifo_rd0, gmii_tx_en0, gmii_tx_er0;
  logic [15:0] ptr_fifo_dout0 = '0;
  logic [7:0]  data_fifo_dout0 = '0;
  logic [7:0]  gmii_txd0;
  logic [31:0] tx_frame_cnt0;
  logic [15:0] tx_drop_cnt0;

  initial forever #4 clk = ~clk;

  mac_tx_gmii #(.IFG_CYCLES(12), .MIN_LEN(60), .MAX_LEN(1514)) dut (
    .clk(clk), .rstn(rstn), .tx_enable(tx_enable),
    .ptr_fifo_empty(ptr_fifo_empty), .ptr_fifo_rd(ptr_fifo_rd), .ptr_fifo_dout(ptr_fifo_dout),
    .data_fifo_rd(data_fifo_rd), .data_fifo_dout(data_fifo_dout),
    .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .tx_frame_cnt(tx_frame_cnt), .tx_drop_cnt(tx_drop_cnt)
  );

  mac_tx_gmii #(.MIN_LEN(0)) dut0 (
    .clk(clk), .rstn(rstn), .tx_enable(tx_enable),
    .ptr_fifo_empty(ptr_fifo_empty0), .ptr_fifo_rd(ptr_fifo_rd0), .ptr_fifo_dout(ptr_fifo_dout0),
    .data_fifo_rd(data_fifo_rd0), .data_fifo_dout(data_fifo_dout0),
    .gmii_txd(gmii_txd0), .gmii_tx_en(gmii_tx_en0), .gmii_tx_er(gmii_tx_er0),
    .tx_frame_cnt(tx_frame_cnt0), .tx_drop_cnt(tx_drop_cnt0)
  );

  int unsigned checks = 0, passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // ---------------- FIFO models (main DUT) ----------------
  logic [15:0] pmem [0:15];
  logic [7:0]  dmem [0:4095];
  int unsigned pwp = 0, prp = 0, dwp = 0, drp = 0, underflow = 0;
  assign ptr_fifo_empty = (pwp == prp);

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      prp <= pwp;
      drp <= dwp;
      ptr_fifo_dout  <= '0;
      data_fifo_dout <= '0;
    end else begin
      if (ptr_fifo_rd) begin
        ptr_fifo_dout <= pmem[prp % 16];
        prp <= prp + 1;
      end
      if (data_fifo_rd) begin
        if (drp == dwp) underflow++;
        else data_fifo_dout <= dmem[drp % 4096];
        drp <= drp + 1;
      end
    end
  end

  // ---------------- FIFO models (MIN_LEN=0 DUT) ----------------
  logic [15:0] desc0 = '0;
  logic [7:0]  d0mem [0:15];
  int unsigned p0w = 0, p0r = 0, d0w = 0, d0r = 0;
  assign ptr_fifo_empty0 = (p0w == p0r);

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      p0r <= p0w;
      d0r <= d0w;
    end else begin
      if (ptr_fifo_rd0) begin
        ptr_fifo_dout0 <= desc0;
        p0r <= p0r + 1;
      end
      if (data_fifo_rd0) begin
        if (d0r == d0w) underflow++;
        else data_fifo_dout0 <= d0mem[d0r % 16];
        d0r <= d0r + 1;
      end
    end
  end

  // ---------------- scoreboard and monitors ----------------
  typedef struct {
    int unsigned len;
    int unsigned rds;
    int unsigned gap;
  } run_t;

  logic [7:0]  exp_q[$];
  logic [7:0]  exp0_q[$];
  run_t        runs[$];
  int unsigned run0_lens[$];
  logic [7:0]  rbuf [0:2047];
  int unsigned idle_rd = 0, ptr_rd_cnt = 0, er_errs = 0;

  initial begin : mon_main
    bit          in_run;
    int unsigned run_len, run_rd, run_gap, gap_len;
    logic [7:0]  e;
    logic [31:0] c;
    in_run = 0; run_len = 0; run_rd = 0; run_gap = 0; gap_len = 0;
    forever begin
      @(negedge clk);
      if (gmii_tx_er !== 1'b0 || gmii_tx_er0 !== 1'b0) er_errs++;
      if (!rstn) begin
        in_run = 0; gap_len = 0;
        exp_q.delete();
      end else begin
        if (ptr_fifo_rd) ptr_rd_cnt++;
        if (gmii_tx_en) begin
          if (!in_run) begin
            in_run = 1; run_len = 0; run_rd = 0; run_gap = gap_len;
          end
          if (run_len < 2048) rbuf[run_len] = gmii_txd;
          run_len++;
          if (data_fifo_rd) run_rd++;
          e = 'x;
          if (exp_q.size() > 0) e = exp_q.pop_front();
          chk("txd", 32'(gmii_txd), 32'(e));
          gap_len = 0;
        end else begin
          if (data_fifo_rd) idle_rd++;
          if (in_run) begin
            in_run = 0;
            c = CRC32_INIT;
            for (int unsigned i = 8; i < run_len && i < 2048; i++) c = crc_step(c, rbuf[i]);
            chk("fcs_residue", reflect32(c), CRC32_RESIDUE);
            runs.push_back('{len: run_len, rds: run_rd, gap: run_gap});
          end
          gap_len++;
        end
      end
    end
  end

  initial begin : mon_zero
    bit          in0;
    int unsigned len0;
    logic [7:0]  e;
    in0 = 0; len0 = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        in0 = 0; len0 = 0;
      end else if (gmii_tx_en0) begin
        in0 = 1; len0++;
        e = 'x;
        if (exp0_q.size() > 0) e = exp0_q.pop_front();
        chk("txd0", 32'(gmii_txd0), 32'(e));
      end else if (in0) begin
        run0_lens.push_back(len0);
        in0 = 0; len0 = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int unsigned len, input logic [7:0] seed);
    logic [31:0] c;
    logic [7:0]  b;
    bit          tx;
    tx = (len != 0) && (len <= 1514);
    c  = 32'hFFFF_FFFF;
    if (tx) begin
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
    end
    for (int unsigned i = 0; i < len; i++) begin
      b = seed + 8'(i);
      dmem[dwp % 4096] = b;
      dwp++;
      if (tx) begin
        exp_q.push_back(b);
        c = crc_step(c, b);
      end
    end
    if (tx) begin
      for (int unsigned i = len; i < 60; i++) begin
        exp_q.push_back(8'h00);
        c = crc_step(c, 8'h00);
      end
      for (int unsigned k = 0; k < 4; k++) exp_q.push_back(8'(~c >> (8 * k)));
    end
    pmem[pwp % 16] = {4'(pwp), 12'(len)};
    pwp++;
  endtask

  task automatic wait_runs(input int unsigned n, input int unsigned budget, input string name);
    int unsigned k = 0;
    while (runs.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(runs.size()), 32'(n));
  endtask

  task automatic wait_tx_en(input string name);
    int unsigned k = 0;
    while (!gmii_tx_en && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(gmii_tx_en), 32'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation stalled, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

  initial begin : stim
    int unsigned rd_before, ptr_before;
    repeat (3) @(negedge clk);
    chk("rst_tx_en",    32'(gmii_tx_en),   32'd0);
    chk("rst_txd",      32'(gmii_txd),     32'd0);
    chk("rst_frame",    tx_frame_cnt,      32'd0);
    chk("rst_drop",     32'(tx_drop_cnt),  32'd0);
    chk("rst_ptr_rd",   32'(ptr_fifo_rd),  32'd0);
    chk("rst_data_rd",  32'(data_fifo_rd), 32'd0);
    chk("rst_tx_en0",   32'(gmii_tx_en0),  32'd0);
    rstn = 1'b1;
    tx_enable = 1'b1;
    @(negedge clk);

    // 9-byte "123456789" frame without padding, upper descriptor bits set
    for (int unsigned i = 0; i < 9; i++) d0mem[i] = 8'h31 + 8'(i);
    d0w = 9;
    repeat (7) exp0_q.push_back(8'h55);
    exp0_q.push_back(8'hD5);
    for (int unsigned i = 0; i < 9; i++) exp0_q.push_back(8'h31 + 8'(i));
    exp0_q.push_back(8'h26); exp0_q.push_back(8'h39);
    exp0_q.push_back(8'hF4); exp0_q.push_back(8'hCB);
    desc0 = 16'hF009;
    p0w = 1;

    // 42-byte frame padded to 60
    send(42, 8'h10);
    wait_runs(1, 500, "t2_frame_seen");
    chk("t2_tx_en_len", runs[0].len, 32'd72);
    chk("t2_reads",     runs[0].rds, 32'd42);
    chk("t2_frame_cnt", tx_frame_cnt, 32'd1);
    chk("t1_runs",      32'(run0_lens.size()), 32'd1);
    if (run0_lens.size() > 0) chk("t1_tx_en_len", run0_lens[0], 32'd21);
    chk("t1_frame_cnt", tx_frame_cnt0, 32'd1);
    chk("t1_all_bytes", 32'(exp0_q.size()), 32'd0);

    // back-to-back 64-byte frames
    send(64, 8'hA0);
    send(64, 8'h40);
    wait_runs(3, 800, "t3_frames_seen");
    chk("t3_len_a",  runs[1].len, 32'd76);
    chk("t3_rds_a",  runs[1].rds, 32'd64);
    chk("t3_len_b",  runs[2].len, 32'd76);
    chk("t3_rds_b",  runs[2].rds, 32'd64);
    chk("t3_gap",    runs[2].gap, 32'd15);
    chk("t3_frames", tx_frame_cnt, 32'd3);

    // oversize drop followed by a minimum-size frame
    rd_before = idle_rd;
    send(1600, 8'h77);
    send(60, 8'hC3);
    wait_runs(4, 3000, "t4_frame_seen");
    chk("t4_drop_reads", idle_rd - rd_before, 32'd1600);
    chk("t4_drop_cnt",   32'(tx_drop_cnt), 32'd1);
    chk("t4_len",        runs[3].len, 32'd72);
    chk("t4_rds",        runs[3].rds, 32'd60);
    chk("t4_frames",     tx_frame_cnt, 32'd4);

    // zero-length descriptor
    rd_before = idle_rd;
    send(0, 8'h00);
    repeat (40) @(negedge clk);
    chk("t5_no_reads",  idle_rd - rd_before, 32'd0);
    chk("t5_drop_cnt",  32'(tx_drop_cnt), 32'd2);
    chk("t5_no_tx",     32'(runs.size()), 32'd4);
    chk("t5_ptr_pops",  ptr_rd_cnt, 32'd6);
    chk("t5_ptr_empty", 32'(ptr_fifo_empty), 32'd1);
    chk("t5_data_left", dwp - drp, 32'd0);

    // tx_enable dropped mid-frame with another descriptor pending
    send(60, 8'h5A);
    wait_tx_en("t6_started");
    repeat (10) @(negedge clk);
    tx_enable = 1'b0;
    send(60, 8'h99);
    ptr_before = ptr_rd_cnt;
    repeat (150) @(negedge clk);
    chk("t6_completed", 32'(runs.size()), 32'd5);
    chk("t6_frames",    tx_frame_cnt, 32'd5);
    chk("t6_no_pop",    ptr_rd_cnt - ptr_before, 32'd0);
    chk("t6_pending",   32'(ptr_fifo_empty), 32'd0);
    tx_enable = 1'b1;
    wait_runs(6, 300, "t6_resumed");
    chk("t6_len",       runs[5].len, 32'd72);
    chk("t6_frames2",   tx_frame_cnt, 32'd6);

    // asynchronous reset in the middle of the data phase
    send(100, 8'h01);
    wait_tx_en("t7_started");
    repeat (30) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("t7_tx_en_async", 32'(gmii_tx_en), 32'd0);
    chk("t7_frame_clr",   tx_frame_cnt, 32'd0);
    chk("t7_drop_clr",    32'(tx_drop_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("t7_idle_after", 32'(runs.size()), 32'd6);
    send(60, 8'hE0);
    wait_runs(7, 300, "t7_recovered");
    chk("t7_len",    runs[6].len, 32'd72);
    chk("t7_frames", tx_frame_cnt, 32'd1);

    repeat (20) @(negedge clk);
    chk("no_underflow", underflow, 32'd0);
    chk("tx_er_zero",   er_errs, 32'd0);
    chk("exp_drained",  32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
